// File: rtl/keccak_dec_pkg.sv
// keccak_dec_pkg: state encoding and default sizing shared by the Keccak decoder controller.
package keccak_dec_pkg;

    localparam int NUM_ROUNDS_DEF = 24;
    localparam int RW_DEF         = 5;
    localparam int TIMEOUT_DEF    = 255;
    localparam int TW_DEF         = 8;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        READ   = 4'd1,
        S_IRC  = 4'd2,
        W_IRC  = 4'd3,
        S_IREV = 4'd4,
        W_IREV = 4'd5,
        S_IPER = 4'd6,
        W_IPER = 4'd7,
        S_IROT = 4'd8,
        W_IROT = 4'd9,
        S_IPAR = 4'd10,
        W_IPAR = 4'd11,
        WRITE  = 4'd12,
        ERR    = 4'd13
    } dec_state_e;

endpackage

// File: rtl/dec_step_waiter.sv
// dec_step_waiter: tracks whether the selected unit has dropped ready (accepted the step)
// and counts wait cycles so a stalled unit is reported as a timeout.
module dec_step_waiter
    import keccak_dec_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int TW      = TW_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic sel_ready,
    output logic done,
    output logic timeout
);

    logic          acc_q, acc_d;
    logic [TW-1:0] tcnt_q, tcnt_d;

    // A high ready only counts once the unit has been seen busy.
    always_comb begin
        done    = en && acc_q && sel_ready;
        timeout = en && !done && (tcnt_q == TW'(TIMEOUT));
        acc_d   = clr ? 1'b0 : (en && !sel_ready) ? 1'b1 : acc_q;
        tcnt_d  = clr ? '0 : (en && !done) ? tcnt_q + 1'b1 : tcnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= 1'b0;
            tcnt_q <= '0;
        end else begin
            acc_q  <= acc_d;
            tcnt_q <= tcnt_d;
        end
    end

endmodule

// File: rtl/keccak_decoder_controller.sv
// keccak_decoder_controller: sequences the inverse round steps (IRC, IREV, IPER, IROT, IPAR)
// for NUM_ROUNDS rounds counting down, with one shared handshake/timeout waiter.
module keccak_decoder_controller
    import keccak_dec_pkg::*;
#(
    parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
    parameter int RW         = RW_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF,
    parameter int TW         = TW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          ready_irc,
    input  logic          ready_irev,
    input  logic          ready_iper,
    input  logic          ready_irot,
    input  logic          ready_ipar,
    output logic          ready,
    output logic          error,
    output logic          start_irc,
    output logic          start_irev,
    output logic          start_iper,
    output logic          start_irot,
    output logic          start_ipar,
    output logic          ld_fr,
    output logic          ld_fw,
    output logic [RW-1:0] round_idx,
    output logic [3:0]    ps
);

    dec_state_e    ps_q, ps_d;
    logic [RW-1:0] round_q, round_d;
    logic [4:0]    start_q;
    logic          ready_q, error_q, ld_fr_q, ld_fw_q;
    logic          sel_ready, wait_en, step_clr, done, timeout;

    assign wait_en   = ps_q inside {W_IRC, W_IREV, W_IPER, W_IROT, W_IPAR};
    assign step_clr  = ps_q inside {S_IRC, S_IREV, S_IPER, S_IROT, S_IPAR};
    assign sel_ready = (ps_q == W_IRC)  ? ready_irc  :
                       (ps_q == W_IREV) ? ready_irev :
                       (ps_q == W_IPER) ? ready_iper :
                       (ps_q == W_IROT) ? ready_irot :
                       (ps_q == W_IPAR) ? ready_ipar : 1'b1;

    dec_step_waiter #(.TIMEOUT(TIMEOUT), .TW(TW)) u_waiter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (step_clr),
        .en        (wait_en),
        .sel_ready (sel_ready),
        .done      (done),
        .timeout   (timeout)
    );

    // Each S_x/W_x pair sits at consecutive codes, so stepping forward is ps+1.
    always_comb begin
        ps_d    = ps_q;
        round_d = round_q;
        case (ps_q)
            IDLE: begin
                ps_d    = start ? READ : IDLE;
                round_d = start ? RW'(NUM_ROUNDS - 1) : round_q;
            end
            READ:                                    ps_d = S_IRC;
            S_IRC, S_IREV, S_IPER, S_IROT, S_IPAR:   ps_d = dec_state_e'(ps_q + 4'd1);
            W_IRC, W_IREV, W_IPER, W_IROT:           ps_d = done ? dec_state_e'(ps_q + 4'd1) : timeout ? ERR : ps_q;
            W_IPAR: begin
                ps_d    = done ? ((round_q == '0) ? WRITE : S_IRC) : timeout ? ERR : ps_q;
                round_d = (done && round_q != '0) ? round_q - 1'b1 : round_q;
            end
            WRITE:                                   ps_d = IDLE;
            ERR:                                     ps_d = start ? IDLE : ERR;
            default:                                 ps_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up exactly with ps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_q    <= IDLE;
            round_q <= RW'(NUM_ROUNDS - 1);
            ready_q <= 1'b1;
            error_q <= 1'b0;
            ld_fr_q <= 1'b0;
            ld_fw_q <= 1'b0;
            start_q <= '0;
        end else begin
            ps_q    <= ps_d;
            round_q <= round_d;
            ready_q <= ps_d == IDLE;
            error_q <= ps_d == ERR;
            ld_fr_q <= ps_d == READ;
            ld_fw_q <= ps_d == WRITE;
            start_q <= {ps_d == S_IPAR, ps_d == S_IROT, ps_d == S_IPER, ps_d == S_IREV, ps_d == S_IRC};
        end
    end

    assign ps         = ps_q;
    assign round_idx  = round_q;
    assign ready      = ready_q;
    assign error      = error_q;
    assign ld_fr      = ld_fr_q;
    assign ld_fw      = ld_fw_q;
    assign start_irc  = start_q[0];
    assign start_irev = start_q[1];
    assign start_iper = start_q[2];
    assign start_irot = start_q[3];
    assign start_ipar = start_q[4];

endmodule

// File: tb/tb_keccak_decoder_controller.sv
// tb_keccak_decoder_controller: behavioural inverse units driven by per-step (delay, busy) profiles;
// observed control pulses are compared against an event timeline computed from the step profiles.
module tb_keccak_decoder_controller;

    localparam int NR = 6, RWB = 3, TO = 15, TWB = 8;

    typedef struct { int a; int b; } prof_t;
    typedef struct { int c; int code; int r; } evt_t;
    typedef struct { int a; int b; int sp; int sa; int sb; int exp_err; int exp_lat; } vec_t;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [4:0] rdy = '1;
    logic ready, error, ld_fr, ld_fw;
    logic start_irc, start_irev, start_iper, start_irot, start_ipar;
    logic [RWB-1:0] round_idx;
    logic [3:0] ps;
    wire  [4:0] st = {start_ipar, start_irot, start_iper, start_irev, start_irc};

    prof_t prof_q[$];
    evt_t  exp_q[$], obs_q[$];
    int    cyc = 0, step_idx = 0, ncmp = 0, nfail = 0;
    int    ua[5] = '{default: 1}, ub[5] = '{default: 0}, uc[5] = '{default: 0};
    logic  err_prev = 1'b0;
    vec_t  tbl[7];

    keccak_decoder_controller #(.NUM_ROUNDS(NR), .RW(RWB), .TIMEOUT(TO), .TW(TWB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .ready_irc(rdy[0]), .ready_irev(rdy[1]), .ready_iper(rdy[2]), .ready_irot(rdy[3]), .ready_ipar(rdy[4]),
        .ready(ready), .error(error),
        .start_irc(start_irc), .start_irev(start_irev), .start_iper(start_iper),
        .start_irot(start_irot), .start_ipar(start_ipar),
        .ld_fr(ld_fr), .ld_fw(ld_fw), .round_idx(round_idx), .ps(ps)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic evt_t mk(input int c, input int code, input int r);
        evt_t e;
        e.c = c; e.code = code; e.r = r;
        return e;
    endfunction

    function automatic prof_t mkp(input int a, input int b);
        prof_t p;
        p.a = a; p.b = b;
        return p;
    endfunction

    function automatic void chk(input string nm, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endfunction

    // Monitor records every pulse; each unit goes busy a cycles after its start for b cycles (b=0: never).
    always @(negedge clk) begin
        if (ld_fr) obs_q.push_back(mk(cyc, 0, int'(round_idx)));
        for (int u = 0; u < 5; u++) begin
            if (st[u]) begin
                obs_q.push_back(mk(cyc, u + 1, int'(round_idx)));
                ua[u] = step_idx < prof_q.size() ? prof_q[step_idx].a : 1;
                ub[u] = step_idx < prof_q.size() ? prof_q[step_idx].b : 1;
                uc[u] = cyc;
                step_idx++;
            end
            rdy[u] = ub[u] == 0 || cyc < uc[u] + ua[u] || cyc >= uc[u] + ua[u] + ub[u];
        end
        if (ld_fw) obs_q.push_back(mk(cyc, 6, int'(round_idx)));
        if (error && !err_prev) obs_q.push_back(mk(cyc, 7, int'(round_idx)));
        err_prev = error;
    end

    // A step takes a+b+1 cycles from its start pulse; if the unit is not done within TO+1 wait cycles, ERR follows.
    function automatic void build_exp(input int s);
        int t, k;
        exp_q.delete();
        exp_q.push_back(mk(s + 1, 0, NR - 1));
        t = s + 2;
        k = 0;
        for (int r = NR - 1; r >= 0; r--)
            for (int u = 0; u < 5; u++) begin
                exp_q.push_back(mk(t, u + 1, r));
                if (prof_q[k].b == 0 || prof_q[k].a + prof_q[k].b - 1 > TO) begin
                    exp_q.push_back(mk(t + TO + 2, 7, r));
                    return;
                end
                t += prof_q[k].a + prof_q[k].b + 1;
                k++;
            end
        exp_q.push_back(mk(t, 6, 0));
    endfunction

    function automatic void fill(input int a, input int b, input int sp, input int sa, input int sb);
        prof_q.delete();
        for (int k = 0; k < 5 * NR; k++) prof_q.push_back(k == sp ? mkp(sa, sb) : mkp(a, b));
    endfunction

    function automatic void fill_rand();
        int a, b;
        prof_q.delete();
        for (int k = 0; k < 5 * NR; k++) begin
            a = $urandom_range(1, 5);
            b = ($urandom_range(0, 39) == 0) ? $urandom_range(12, 18) : $urandom_range(1, 6);
            prof_q.push_back(mkp(a, b));
        end
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    // mode 0: plain decode, 1: start poked during W_IRC and WRITE, 2: reset during W_IREV at round_idx 1.
    task automatic run_decode(input int mode, output int lat, output int got_err);
        int s, nfw;
        bit fin, hit;
        s = cyc;
        build_exp(s);
        obs_q.delete();
        step_idx = 0;
        fin = 0;
        hit = 0;
        lat = -1;
        got_err = 0;
        start = 1'b1;
        for (int n = 0; n < 2000 && !fin; n++) begin
            @(negedge clk);
            #1 start = mode == 1 && (ps == 4'd3 || ps == 4'd12);
            if (mode == 2 && ps == 4'd5 && round_idx == RWB'(1)) begin
                rst_n = 1'b0;
                #1;
                chk("async_rst_ps", int'(ps), 0);
                chk("async_rst_ready", int'(ready), 1);
                chk("async_rst_round", int'(round_idx), NR - 1);
                chk("async_rst_outs", int'({error, ld_fr, ld_fw, st}), 0);
                hit = 1;
                fin = 1;
            end else fin = error || ready;
        end
        chk("decode_bound", int'(fin), 1);
        if (mode == 2) begin
            chk("rst_hit", int'(hit), 1);
            repeat (2) @(negedge clk);
            #1 rst_n = 1'b1;
            nfw = 0;
            foreach (obs_q[i]) if (obs_q[i].code == 6) nfw++;
            chk("rst_no_ldfw", nfw, 0);
            return;
        end
        lat = obs_q.size() > 0 ? obs_q[obs_q.size() - 1].c - s : -1;
        got_err = int'(error);
        chk("evt_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk($sformatf("evt%0d_cycle", i), obs_q[i].c - s, exp_q[i].c - s);
            chk($sformatf("evt%0d_kind", i), obs_q[i].code, exp_q[i].code);
            chk($sformatf("evt%0d_round", i), obs_q[i].r, exp_q[i].r);
        end
        if (error) begin
            chk("err_ready", int'(ready), 0);
            start = 1'b1;
            @(negedge clk);
            #1 start = 1'b0;
            chk("err_to_idle", int'(ps), 0);
            chk("err_idle_ready", int'(ready), 1);
            @(negedge clk);
            #1 chk("err_no_autostart", int'(ps), 0);
        end else
            repeat (2) begin
                @(negedge clk);
                #1 chk("idle_hold", int'(ps), 0);
            end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int lat, ge;
        tbl[0] = '{1, 2, -1, 0, 0, 0, 122};
        tbl[1] = '{1, 2, 2, 1, 0, 1, 27};
        tbl[2] = '{1, 2, 3, 1, 15, 0, 135};
        tbl[3] = '{1, 2, 3, 1, 16, 1, 31};
        tbl[4] = '{4, 2, -1, 0, 0, 0, 212};
        tbl[5] = '{1, 1, -1, 0, 0, 0, 92};
        tbl[6] = '{16, 1, -1, 0, 0, 1, 19};
        @(negedge clk);
        #1;
        chk("rst_ps", int'(ps), 0);
        chk("rst_ready", int'(ready), 1);
        chk("rst_error", int'(error), 0);
        chk("rst_round", int'(round_idx), NR - 1);
        chk("rst_pulses", int'({ld_fr, ld_fw, st}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        #1 chk("idle_after_rst", int'(ps), 0);
        for (int i = 0; i < 7; i++) begin
            fill(tbl[i].a, tbl[i].b, tbl[i].sp, tbl[i].sa, tbl[i].sb);
            run_decode(0, lat, ge);
            chk($sformatf("tbl%0d_error", i), ge, tbl[i].exp_err);
            chk($sformatf("tbl%0d_latency", i), lat, tbl[i].exp_lat);
        end
        fill(1, 2, 2, 1, 0);
        run_decode(0, lat, ge);
        start = 1'b1;
        @(negedge clk);
        #1 start = 1'b0;
        chk("restart_ps", int'(ps), 1);
        chk("restart_ldfr", int'(ld_fr), 1);
        do_reset();
        fill(1, 2, -1, 0, 0);
        run_decode(1, lat, ge);
        chk("poke_latency", lat, 122);
        fill(1, 2, -1, 0, 0);
        run_decode(2, lat, ge);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            fill_rand();
            #1 run_decode(0, lat, ge);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
